aca_vl_adder: RTL and testbench
===============================

# aca_vl_adder

Variable-latency accuracy-configurable adder. It computes an N-bit speculative sum in which each bit i ≥ K sees only a K-bit window (bits i-K+1..i, window carry-in 0) and flags an error when that sum differs from the exact sum. In exact mode it then repairs the result with a K-bit-per-cycle segmented ripple pass. It sits behind valid/ready handshakes, so datapath users can trade latency for accuracy per operation.

## Interface
- N, 32: operand width, N ≥ 2
- K, 8: speculation window width, 2 ≤ K ≤ N; S = ceil(N/K) correction segments
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  N  operand A
- b  in  N  operand B
- cin  in  1  carry-in; used by the lowest window and by correction
- approx_mode  in  1  1: return speculative result, flag only; 0: correct on error
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  N  result
- cout  out  1  result carry-out
- err  out  1  speculative {cout,sum} differed from exact
- corrected  out  1  result came from the correction pass

## Operation
- FSM states: IDLE, CHECK, CORR, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register a, b, cin, approx_mode, then go to CHECK.
- CHECK: compute the speculative result from the registered operands.
  - Bits 0..K-1 are exact, including cin.
  - Bit i ≥ K is the MSB of the K-bit window sum over bits i-K+1..i, with window carry-in 0.
  - Speculative cout is the carry-out of window N-K..N-1. If K = N, the speculative cout equals the exact cout.
  - err_d = (speculative {cout,sum} != exact {cout,sum}). Detection may use any logic that is exactly equivalent.
  - Transitions: !err_d or approx_mode → load the speculative result, corrected=0, go to DONE. Otherwise go to CORR with seg=0 and carry=cin.
- CORR: each cycle adds segment seg (bits seg·K up to min(seg·K+K, N)-1; the last segment may be narrower) plus carry, writes that sum slice, and updates carry. After seg=S-1: cout=carry, corrected=1, go to DONE.
- DONE: out_valid=1. Outputs stay stable until out_ready. On out_valid&&out_ready go to IDLE.
- err is held with the result in every path.
- One operation in flight. in_ready=0 outside IDLE.
- Arithmetic is unsigned modulo 2^N. Carry leaves only through cout.

## Timing
- Accept at edge t. CHECK occupies cycle t+1.
- No correction: out_valid is first high in cycle t+2 (latency 2).
- Correction: CORR occupies cycles t+2..t+1+S. out_valid is first high in cycle t+2+S.
- Back-to-back: after the out handshake at edge u, in_ready=1 in cycle u+1.
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE. in_ready=1, out_valid=0.
  - sum=0, cout=0, err=0, corrected=0.
  - Any in-flight operation is discarded. This holds in any state, including mid-CORR.
- Inputs other than out_ready are ignored outside IDLE. approx_mode is sampled only at accept.

## Configuration
- ACA_VL_ERRCNT_EN defined:
  - Adds output err_count (32 bits, reset 0). It increments on every DONE handshake with err=1 and saturates at 2^32-1.
  - Adds input err_count_clr (1 bit), which zeroes the counter synchronously. If clear and increment coincide, clear wins.
- Undefined: neither port exists and there is no counter logic.

## Structure
- Package aca_pkg holds:
  - the state enum typedef aca_vl_state_t {IDLE, CHECK, CORR, DONE};
  - the segment-count function seg_count(N,K) = ceil(N/K).
- Sub-module aca_window: K-bit window adder with carry-in, returning sum MSB and carry-out. It is instantiated N-K+1 times for the speculative path. The lowest instance gets cin; all others get 0 and expose only the MSB.
- The correction segment adder and FSM live in the top module.

## Test plan
Use N=16, K=4 (S=4).
- Clean add: a=0x0001, b=0x0002, cin=0, approx_mode=0 → sum=0x0003, cout=0, err=0, corrected=0, out_valid in cycle t+2.
- Long chain, exact mode: a=0x00FF, b=0x0001, approx_mode=0 → err=1, corrected=1, sum=0x0100, cout=0, out_valid in cycle t+6.
- Long chain, approx mode: same operands with approx_mode=1 → sum=0x00F0, err=1, corrected=0, out_valid in cycle t+2.
- Carry-in chain: a=0xFFFF, b=0x0000, cin=1.
  - approx_mode=1 → sum=0xFFF0, cout=0, err=1.
  - approx_mode=0 → sum=0x0000, cout=1, corrected=1.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in DONE → outputs stable and in_ready=0. Then the handshake completes and in_ready=1 in the next cycle.
  - Separately, rst_n=0 during the second CORR cycle → all outputs take their reset values, and the next operation computes correctly.
- With ACA_VL_ERRCNT_EN: run the three erroring cases above → err_count=3. Assert err_count_clr in the same cycle as an erroring handshake → err_count=0.

Source files
------------

// File: rtl/aca_pkg.sv
// Shared types and helpers for the variable-latency accuracy-configurable adder.
package aca_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CORR,
        DONE
    } aca_vl_state_t;

    function automatic int seg_count(input int n, input int k);
        return (n + k - 1) / k;
    endfunction

endpackage

// File: rtl/aca_vl_adder_if.sv
// Operand request and result channels of aca_vl_adder, each a valid/ready pair.
interface aca_vl_adder_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         approx_mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         err;
    logic         corrected;

    modport master (
        output in_valid, a, b, cin, approx_mode, out_ready,
        input  in_ready, out_valid, sum, cout, err, corrected
    );

    modport slave (
        input  in_valid, a, b, cin, approx_mode, out_ready,
        output in_ready, out_valid, sum, cout, err, corrected
    );
endinterface

// File: rtl/aca_window.sv
// K-bit window adder: returns sum MSB and carry-out for the speculative path.
// Latency: combinational. Backpressure: none.
module aca_window #(
    parameter int K = 8
) (
    input  logic [K-1:0] a_i,
    input  logic [K-1:0] b_i,
    input  logic         c_i,
    output logic         msb_o,
    output logic         co_o
);
    logic [K:0] s;

    assign s     = {1'b0, a_i} + {1'b0, b_i} + {{K{1'b0}}, c_i};
    assign msb_o = s[K-1];
    assign co_o  = s[K];
endmodule

// File: rtl/aca_vl_adder.sv
// Variable-latency adder: speculative windowed sum, repaired K bits/cycle on error.
// Latency: 2 cycles clean or approx, 2+S with correction. Optional ACA_VL_ERRCNT_EN error counter.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module aca_vl_adder
    import aca_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    aca_vl_adder_if.slave io
`ifdef ACA_VL_ERRCNT_EN
    ,
    input  logic         err_count_clr,
    output logic [31:0]  err_count
`endif
);
    localparam int S     = seg_count(N, K);
    localparam int SW    = (S > 1) ? $clog2(S) : 1;
    localparam int LASTW = N - (S - 1) * K;
    localparam logic [N-1:0] KMASK = N'({K{1'b1}});

    aca_vl_state_t state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          cin_q, cin_d, approx_q, approx_d, carry_q, carry_d;
    logic          cout_q, cout_d, err_q, err_d, corrected_q, corrected_d;
    logic [SW-1:0] seg_q, seg_d;

    logic [N:0]    exact;
    logic [N-K:0]  win_msb, win_co;
    logic [N-1:0]  spec_sum;
    logic          spec_cout, spec_err;

    assign exact = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};

    // Window j covers bits j..j+K-1; only the lowest one sees cin.
    for (genvar j = 0; j <= N - K; j++) begin : g_win
        aca_window #(.K(K)) u_win (
            .a_i   (a_q[j+K-1:j]),
            .b_i   (b_q[j+K-1:j]),
            .c_i   ((j == 0) ? cin_q : 1'b0),
            .msb_o (win_msb[j]),
            .co_o  (win_co[j])
        );
    end

    assign spec_sum  = {win_msb, exact[K-2:0]};
    assign spec_cout = win_co[N-K];
    assign spec_err  = ({spec_cout, spec_sum} != exact);

    logic [31:0]  seg_sh;
    logic [K-1:0] seg_a, seg_b;
    logic [K:0]   seg_sum;
    logic [N-1:0] seg_ins, seg_mask;
    logic         seg_co;

    assign seg_sh   = 32'(seg_q) * 32'(K);
    assign seg_a    = K'(a_q >> seg_sh);
    assign seg_b    = K'(b_q >> seg_sh);
    assign seg_sum  = {1'b0, seg_a} + {1'b0, seg_b} + {{K{1'b0}}, carry_q};
    assign seg_ins  = N'(seg_sum[K-1:0]) << seg_sh;
    assign seg_mask = KMASK << seg_sh;
    // The last segment may be narrower, so its carry sits at bit LASTW.
    assign seg_co   = (seg_q == SW'(S - 1)) ? seg_sum[LASTW] : seg_sum[K];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            approx_q    <= 1'b0;
            carry_q     <= 1'b0;
            seg_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            corrected_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            approx_q    <= approx_d;
            carry_q     <= carry_d;
            seg_q       <= seg_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
            corrected_q <= corrected_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        approx_d    = approx_q;
        carry_d     = carry_q;
        seg_d       = seg_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        err_d       = err_q;
        corrected_d = corrected_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d      = io.a;
                    b_d      = io.b;
                    cin_d    = io.cin;
                    approx_d = io.approx_mode;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                err_d       = spec_err;
                corrected_d = 1'b0;
                if (!spec_err || approx_q) begin
                    sum_d   = spec_sum;
                    cout_d  = spec_cout;
                    state_d = DONE;
                end else begin
                    seg_d   = '0;
                    carry_d = cin_q;
                    state_d = CORR;
                end
            end
            CORR: begin
                sum_d   = (sum_q & ~seg_mask) | seg_ins;
                carry_d = seg_co;
                if (seg_q == SW'(S - 1)) begin
                    cout_d      = seg_co;
                    corrected_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    seg_d = seg_q + SW'(1);
                end
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign io.err       = err_q;
    assign io.corrected = corrected_q;

`ifdef ACA_VL_ERRCNT_EN
    logic [31:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (err_count_clr) begin
            err_count_d = '0;
        end else if ((state_q == DONE) && io.out_ready && err_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_count_q <= '0;
        else        err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_aca_vl_adder.sv
// Directed + random bench for aca_vl_adder at N=16, K=4 with a result scoreboard.
module tb_aca_vl_adder;
    localparam int N = 16;
    localparam int K = 4;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aca_vl_adder_if #(.N(N)) io();

`ifdef ACA_VL_ERRCNT_EN
    logic        err_count_clr;
    logic [31:0] err_count;
`endif

    aca_vl_adder #(.N(N), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
`ifdef ACA_VL_ERRCNT_EN
        ,
        .err_count_clr (err_count_clr),
        .err_count     (err_count)
`endif
    );

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         err;
        logic         corr;
        int           lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] s, input logic c, input logic e,
                                input logic k, input int l);
        exp_t r;
        r.sum = s; r.cout = c; r.err = e; r.corr = k; r.lat = l;
        return r;
    endfunction

    // Reference: windowed speculative sum from its definition, exact sum, and latency.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic ci, input logic am);
        logic [N:0]   ex;
        logic [N-1:0] sp;
        logic [K:0]   w;
        logic         spc;
        logic         e;
        ex = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
        sp = ex[N-1:0];
        for (int i = K; i < N; i++) begin
            w = {1'b0, K'(a >> (i - K + 1))} + {1'b0, K'(b >> (i - K + 1))};
            sp[i] = w[K-1];
        end
        w   = {1'b0, K'(a >> (N - K))} + {1'b0, K'(b >> (N - K))};
        spc = w[K];
        e   = ({spc, sp} != ex);
        if (e && !am) return mk(ex[N-1:0], ex[N], 1'b1, 1'b1, 2 + S);
        return mk(sp, spc, e, 1'b0, 2);
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(io.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(io.out_valid), 32'd0);
        chk({tag, "_sum"},       32'(io.sum), 32'd0);
        chk({tag, "_cout"},      32'(io.cout), 32'd0);
        chk({tag, "_err"},       32'(io.err), 32'd0);
        chk({tag, "_corrected"}, 32'(io.corrected), 32'd0);
`ifdef ACA_VL_ERRCNT_EN
        chk({tag, "_err_count"}, err_count, 32'd0);
`endif
    endtask

    task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic ci, input logic am, input exp_t e,
                         input int hold, input logic clr);
        int   n;
        exp_t g;
        chk({tag, "_in_ready_idle"}, 32'(io.in_ready), 32'd1);
        io.a = a; io.b = b; io.cin = ci; io.approx_mode = am; io.in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        io.a = N'($urandom); io.b = N'($urandom); io.approx_mode = ~am;
        n = 0;
        while (io.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_out_valid"}, 32'(io.out_valid), 32'd1);
        g = sb.pop_front();
        chk({tag, "_latency"},   32'(n + 1), 32'(g.lat));
        chk({tag, "_sum"},       32'(io.sum), 32'(g.sum));
        chk({tag, "_cout"},      32'(io.cout), 32'(g.cout));
        chk({tag, "_err"},       32'(io.err), 32'(g.err));
        chk({tag, "_corrected"}, 32'(io.corrected), 32'(g.corr));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(io.out_valid), 32'd1);
            chk({tag, "_hold_sum"},   32'(io.sum), 32'(g.sum));
            chk({tag, "_hold_err"},   32'(io.err), 32'(g.err));
            chk({tag, "_hold_ready"}, 32'(io.in_ready), 32'd0);
        end
        io.out_ready = 1'b1;
`ifdef ACA_VL_ERRCNT_EN
        err_count_clr = clr;
`endif
        @(posedge clk); #1;
        io.out_ready = 1'b0;
`ifdef ACA_VL_ERRCNT_EN
        err_count_clr = 1'b0;
`endif
        if (clr) exp_cnt = 32'd0;
        else if (g.err && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
        chk({tag, "_post_in_ready"},  32'(io.in_ready), 32'd1);
        chk({tag, "_post_out_valid"}, 32'(io.out_valid), 32'd0);
`ifdef ACA_VL_ERRCNT_EN
        chk({tag, "_err_count"}, err_count, exp_cnt);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ra, rb;
        logic         rc, rm;
        io.in_valid = 1'b0; io.out_ready = 1'b0;
        io.a = '0; io.b = '0; io.cin = 1'b0; io.approx_mode = 1'b0;
`ifdef ACA_VL_ERRCNT_EN
        err_count_clr = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_vals("reset");

        do_op("clean",       16'h0001, 16'h0002, 1'b0, 1'b0, mk(16'h0003, 1'b0, 1'b0, 1'b0, 2), 0, 1'b0);
        do_op("chain_exact", 16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b1, 1'b1, 6), 0, 1'b0);
        do_op("chain_apx",   16'h00FF, 16'h0001, 1'b0, 1'b1, mk(16'h00F0, 1'b0, 1'b1, 1'b0, 2), 0, 1'b0);
        do_op("cin_apx",     16'hFFFF, 16'h0000, 1'b1, 1'b1, mk(16'hFFF0, 1'b0, 1'b1, 1'b0, 2), 0, 1'b0);
        do_op("cin_exact",   16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b1, 6), 0, 1'b0);
        do_op("bp_hold",     16'h1234, 16'h0101, 1'b0, 1'b0, mk(16'h1335, 1'b0, 1'b0, 1'b0, 2), 3, 1'b0);

        // Reset during the second CORR cycle discards the operation.
        io.a = 16'h00FF; io.b = 16'h0001; io.cin = 1'b0; io.approx_mode = 1'b0;
        io.in_valid = 1'b1;
        sb.push_back(mk(16'h0100, 1'b0, 1'b1, 1'b1, 6));
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midcorr_busy", 32'(io.in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = 32'd0;
        check_reset_vals("midcorr_reset");

        do_op("after_rst",   16'h0FFF, 16'h0001, 1'b0, 1'b0, mk(16'h1000, 1'b0, 1'b1, 1'b1, 6), 0, 1'b0);
        do_op("wrap",        16'hF000, 16'h1000, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b0, 2), 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            ra = N'($urandom); rb = N'($urandom);
            rc = 1'($urandom); rm = 1'($urandom);
            do_op("rand", ra, rb, rc, rm, model(ra, rb, rc, rm), r % 2, 1'b0);
        end

        do_op("clr_on_err",  16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b1, 1'b1, 6), 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
